// File: rtl/bicubic_job_sched.sv
// Job scheduler for the Bicubic scaling engine.
// Queues ROI/scale jobs, rejects malformed ones, sequences the engine through
// reset / parameter load / start, waits for DONE and relocates engine writes
// into each job's output region.
// Optional feature: define BICUBIC_SCHED_TIMEOUT_EN to enable the RUN watchdog.
module bicubic_job_sched #(
  parameter int DEPTH       = 4,
  parameter int IMG_DIM     = 100,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_job_valid,
  output logic        o_job_ready,
  input  logic [6:0]  i_job_v0,
  input  logic [6:0]  i_job_h0,
  input  logic [4:0]  i_job_sw,
  input  logic [4:0]  i_job_sh,
  input  logic [5:0]  i_job_tw,
  input  logic [5:0]  i_job_th,
  input  logic [13:0] i_job_base,
  output logic        o_eng_rst,
  output logic        o_eng_enable,
  output logic [6:0]  o_eng_v0,
  output logic [6:0]  o_eng_h0,
  output logic [4:0]  o_eng_sw,
  output logic [4:0]  o_eng_sh,
  output logic [5:0]  o_eng_tw,
  output logic [5:0]  o_eng_th,
  input  logic        i_eng_done,
  input  logic        i_eng_we,
  input  logic [13:0] i_eng_waddr,
  output logic        o_mem_we,
  output logic [13:0] o_mem_waddr,
  output logic        o_job_done,
  output logic        o_job_err,
  output logic        o_busy
);

  typedef struct packed {
    logic [6:0]  v0;
    logic [6:0]  h0;
    logic [4:0]  sw;
    logic [4:0]  sh;
    logic [5:0]  tw;
    logic [5:0]  th;
    logic [13:0] base;
  } job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_RSTE, S_LOAD, S_START, S_RUN, S_RETIRE
  } state_t;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC + 1) : 1;

  state_t        r_state, w_state_next;
  job_t          r_fifo [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_ready_en;
  logic          r_done_prev;
  logic [RW-1:0] r_rst_cnt;
  logic [13:0]   r_base;
  logic [6:0]    r_eng_v0, r_eng_h0;
  logic [4:0]    r_eng_sw, r_eng_sh;
  logic [5:0]    r_eng_tw, r_eng_th;

  job_t w_head;
  logic w_full, w_empty, w_push, w_pop, w_illegal, w_done_rise;
  logic w_timeout, w_abort;

  assign w_head  = r_fifo[r_rd_ptr];
  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  // A job is rejected when it is too small to interpolate or its ROI leaves the image.
  assign w_illegal = (w_head.tw < 6'd2) || (w_head.th < 6'd2) ||
                     (w_head.sw < 5'd2) || (w_head.sh < 5'd2) ||
                     ((int'(w_head.v0) + int'(w_head.sh)) > IMG_DIM) ||
                     ((int'(w_head.h0) + int'(w_head.sw)) > IMG_DIM);

  // Ready also while full if an entry leaves this cycle, so push+pop keeps occupancy.
  assign o_job_ready = r_ready_en && (!w_full || w_pop);
  assign w_push      = i_job_valid && o_job_ready;
  assign w_done_rise = i_eng_done && !r_done_prev;
  assign o_mem_waddr = r_base + i_eng_waddr;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;

  assign o_eng_v0 = r_eng_v0;
  assign o_eng_h0 = r_eng_h0;
  assign o_eng_sw = r_eng_sw;
  assign o_eng_sh = r_eng_sh;
  assign o_eng_tw = r_eng_tw;
  assign o_eng_th = r_eng_th;

`ifdef BICUBIC_SCHED_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] r_wdog;
  logic          r_timed_out;

  // Threshold chosen so RETIRE lands exactly TIMEOUT_CYC cycles after START.
  assign w_timeout = (r_state == S_RUN) && (r_wdog >= WW'(TIMEOUT_CYC - 2));
  assign w_abort   = r_timed_out;

  // Watchdog: cleared at START, counts RUN cycles; remembers whether RUN ended by abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog      <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == S_START) begin
      r_wdog      <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_wdog <= r_wdog + 1'b1;
      if (w_timeout && !w_done_rise) r_timed_out <= 1'b1;
    end
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign w_timeout = 1'b0;
  assign w_abort   = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_empty) w_state_next = S_CHECK;
      S_CHECK:  w_state_next = w_illegal ? S_IDLE : S_RSTE;
      S_RSTE:   if (r_rst_cnt == RW'(RST_CYC - 1)) w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_START;
      S_START:  w_state_next = S_RUN;
      S_RUN:    if (w_done_rise || w_timeout) w_state_next = S_RETIRE;
      S_RETIRE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output decode: engine control, write gating, retire pulses and FIFO pop.
  always_comb begin
    o_eng_rst    = 1'b1;
    o_eng_enable = 1'b0;
    o_mem_we     = 1'b0;
    o_job_done   = 1'b0;
    o_job_err    = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      S_CHECK: begin
        if (w_illegal) begin
          w_pop     = 1'b1;
          o_job_err = 1'b1;
        end
      end
      S_LOAD:  o_eng_rst = 1'b0;
      S_START: begin
        o_eng_rst    = 1'b0;
        o_eng_enable = 1'b1;
      end
      S_RUN: begin
        o_eng_rst = 1'b0;
        o_mem_we  = i_eng_we;
      end
      S_RETIRE: begin
        w_pop = 1'b1;
        if (w_abort) o_job_err  = 1'b1;
        else         o_job_done = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: the job storage has no reset; only pointers and count define what is valid.
  // Job storage write port.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{v0: i_job_v0, h0: i_job_h0, sw: i_job_sw, sh: i_job_sh,
                            tw: i_job_tw, th: i_job_th, base: i_job_base};
    end
  end

  // FIFO bookkeeping, DONE edge history, reset-hold counter and engine parameter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_ready_en  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_done_prev <= 1'b0;
      r_rst_cnt   <= '0;
      r_base      <= '0;
      r_eng_v0    <= '0;
      r_eng_h0    <= '0;
      r_eng_sw    <= '0;
      r_eng_sh    <= '0;
      r_eng_tw    <= '0;
      r_eng_th    <= '0;
    end else begin
      r_ready_en  <= 1'b1;
      r_done_prev <= i_eng_done;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_state == S_CHECK)     r_rst_cnt <= '0;
      else if (r_state == S_RSTE) r_rst_cnt <= r_rst_cnt + 1'b1;
      if (r_state == S_LOAD) begin
        r_eng_v0 <= w_head.v0;
        r_eng_h0 <= w_head.h0;
        r_eng_sw <= w_head.sw;
        r_eng_sh <= w_head.sh;
        r_eng_tw <= w_head.tw;
        r_eng_th <= w_head.th;
        r_base   <= w_head.base;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_job_sched.sv
// Self-checking bench for bicubic_job_sched: directed scenarios plus randomized
// jobs, checked against a job-queue reference model and a simple engine model.
module tb_bicubic_job_sched;
  localparam int DEPTH       = 4;
  localparam int IMG_DIM     = 100;
  localparam int RST_CYC     = 2;
  localparam int TIMEOUT_CYC = 50;

  typedef struct {
    int v0, h0, sw, sh, tw, th, base;
    bit tmo;
  } job_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_valid = 1'b0, job_ready;
  logic [6:0] job_v0 = '0, job_h0 = '0;
  logic [4:0] job_sw = '0, job_sh = '0;
  logic [5:0] job_tw = '0, job_th = '0;
  logic [13:0] job_base = '0;
  logic eng_rst, eng_enable;
  logic [6:0] eng_v0, eng_h0;
  logic [4:0] eng_sw, eng_sh;
  logic [5:0] eng_tw, eng_th;
  logic eng_done, eng_we;
  logic [13:0] eng_waddr;
  logic mem_we;
  logic [13:0] mem_waddr;
  logic job_done, job_err, busy;

  always #5 clk = ~clk;

  bicubic_job_sched #(.DEPTH(DEPTH), .IMG_DIM(IMG_DIM), .RST_CYC(RST_CYC),
                      .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_v0(job_v0), .i_job_h0(job_h0), .i_job_sw(job_sw), .i_job_sh(job_sh),
    .i_job_tw(job_tw), .i_job_th(job_th), .i_job_base(job_base),
    .o_eng_rst(eng_rst), .o_eng_enable(eng_enable),
    .o_eng_v0(eng_v0), .o_eng_h0(eng_h0), .o_eng_sw(eng_sw), .o_eng_sh(eng_sh),
    .o_eng_tw(eng_tw), .o_eng_th(eng_th),
    .i_eng_done(eng_done), .i_eng_we(eng_we), .i_eng_waddr(eng_waddr),
    .o_mem_we(mem_we), .o_mem_waddr(mem_waddr),
    .o_job_done(job_done), .o_job_err(job_err), .o_busy(busy)
  );

  int total = 0, passed = 0, failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input job_t j);
    return !(j.tw < 2 || j.th < 2 || j.sw < 2 || j.sh < 2 ||
             j.v0 + j.sh > IMG_DIM || j.h0 + j.sw > IMG_DIM);
  endfunction

  function automatic logic [35:0] pk(input job_t j);
    return {7'(j.v0), 7'(j.h0), 5'(j.sw), 5'(j.sh), 6'(j.tw), 6'(j.th)};
  endfunction

  function automatic logic [35:0] dut_params();
    return {eng_v0, eng_h0, eng_sw, eng_sh, eng_tw, eng_th};
  endfunction

  function automatic job_t mk(input int v0, h0, sw, sh, tw, th, base);
    job_t j;
    j = '{v0: v0, h0: h0, sw: sw, sh: sh, tw: tw, th: th, base: base, tmo: 1'b0};
    return j;
  endfunction

  // Engine model: after enable writes tw*th consecutive addresses, then raises
  // DONE for done_hold cycles. DONE hold is not cleared by eng_rst.
  int  e_cnt = 0, e_total = 0, e_hold = 0, done_hold = 1;
  bit  e_run = 1'b0, e_we = 1'b0, never_done = 1'b0, we_force = 1'b0;
  logic [13:0] e_waddr = '0;
  assign eng_we    = e_we | we_force;
  assign eng_waddr = e_waddr;
  assign eng_done  = (e_hold != 0);

  always @(posedge clk) begin
    if (e_hold != 0) e_hold <= e_hold - 1;
    if (!rst_n || eng_rst) begin
      e_run <= 1'b0; e_cnt <= 0; e_we <= 1'b0;
      if (!rst_n) e_hold <= 0;
    end else if (eng_enable) begin
      e_run <= 1'b1; e_cnt <= 0; e_we <= 1'b0;
      e_total <= int'(eng_tw) * int'(eng_th);
    end else if (e_run) begin
      if (e_cnt < e_total) begin
        e_we <= 1'b1; e_waddr <= 14'(e_cnt); e_cnt <= e_cnt + 1;
      end else begin
        e_we <= 1'b0;
        if (!never_done) begin e_run <= 1'b0; e_hold <= done_hold; end
      end
    end
  end

  // Reference model: queue of accepted jobs, retired strictly in order.
  job_t exp_q[$];
  job_t cur, rj;
  bit   active = 1'b0, post_retire = 1'b0, expect_start = 1'b0, ok;
  int   wcnt = 0, t_start = 0, t_retire = 0;
  int   n_enable = 0, n_done = 0, n_err = 0;
  logic [13:0] first_addr = '0, last_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      active = 1'b0; post_retire = 1'b0; expect_start = 1'b0;
    end else begin
      if (post_retire) begin
        check("rst_after_retire", eng_rst, 1);
        post_retire = 1'b0;
      end
      if (eng_enable) begin
        n_enable++;
        check("start_has_job", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          cur = exp_q[0];
          check("start_legal", legal(cur), 1);
          check("start_params", dut_params(), pk(cur));
          if (expect_start) check("b2b_gap", cyc - t_retire, RST_CYC + 4);
        end
        expect_start = 1'b0; active = 1'b1; wcnt = 0; t_start = cyc;
      end
      if (mem_we) begin
        check("wr_in_run", active, 1);
        check("waddr", mem_waddr, (cur.base + wcnt) % 16384);
        if (wcnt == 0) first_addr = mem_waddr;
        last_addr = mem_waddr;
        wcnt++;
      end
      if (job_done || job_err) begin
        check("done_err_exclusive", {job_done, job_err} != 2'b11, 1);
        check("retire_has_job", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          rj = exp_q.pop_front();
          ok = legal(rj) && !rj.tmo;
          check("outcome", {job_done, job_err}, ok ? 2'b10 : 2'b01);
          if (ok) begin
            check("wr_count", wcnt, rj.tw * rj.th);
            check("held_params", dut_params(), pk(rj));
          end
          if (legal(rj) && rj.tmo) check("timeout_latency", cyc - t_start, TIMEOUT_CYC);
          if (legal(rj)) begin
            post_retire = 1'b1;
            t_retire = cyc;
            expect_start = (exp_q.size() != 0) && legal(exp_q[0]);
          end
        end
        if (job_done) n_done++;
        else          n_err++;
        active = 1'b0;
      end
    end
  end

  task automatic push(input job_t j, input int budget, output bit acc, output bit in_retire);
    bit rdy, dn;
    acc = 1'b0; in_retire = 1'b0;
    @(negedge clk);
    job_v0 = 7'(j.v0); job_h0 = 7'(j.h0); job_sw = 5'(j.sw); job_sh = 5'(j.sh);
    job_tw = 6'(j.tw); job_th = 6'(j.th); job_base = 14'(j.base);
    job_valid = 1'b1;
    for (int i = 0; i < budget; i++) begin
      rdy = job_ready; dn = job_done;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1; in_retire = dn; exp_q.push_back(j);
        break;
      end
      @(negedge clk);
    end
    #1 job_valid = 1'b0;
  endtask

  task automatic push_ok(input string tag, input job_t j);
    bit acc, ir;
    push(j, 400, acc, ir);
    check(tag, acc, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin seen = 1'b1; break; end
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_enable(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_enable) begin seen = 1'b1; break; end
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    int  e0, d0, r0;
    bit  acc, ir;
    job_t j;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_eng_enable", eng_enable, 0);
    check("rst_params", dut_params(), 0);
    check("rst_job_done", job_done, 0);
    check("rst_job_err", job_err, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", job_ready, 0);
    check("rst_mem_we", mem_we, 0);
    #2 rst_n = 1'b1;
    #1 check("ready_low_at_release", job_ready, 0);
    @(negedge clk);
    check("ready_after_release", job_ready, 1);

    // Single job 8x8, base 0x100
    e0 = n_enable; d0 = n_done;
    push_ok("push_basic", mk(10, 20, 4, 4, 8, 8, 'h100));
    wait_idle("drain_basic", 400);
    check("basic_one_enable", n_enable - e0, 1);
    check("basic_one_done", n_done - d0, 1);
    check("basic_first_addr", first_addr, 'h100);
    check("basic_last_addr", last_addr, 'h13F);

    // Address wraps modulo 2^14
    push_ok("push_wrap", mk(0, 0, 2, 2, 2, 4, 'h3FFA));
    wait_idle("drain_wrap", 300);
    check("wrap_last_addr", last_addr, 'h0001);

    // Engine writes outside RUN are dropped
    we_force = 1'b1;
    @(negedge clk);
    check("idle_write_dropped", mem_we, 0);
    we_force = 1'b0;

    // Illegal jobs, then a legal one and an exact-boundary legal one
    e0 = n_enable; d0 = n_done; r0 = n_err;
    push_ok("push_bad_tw", mk(10, 20, 4, 4, 1, 8, 0));
    push_ok("push_bad_h0", mk(10, 98, 4, 4, 8, 8, 0));
    push_ok("push_good", mk(0, 0, 2, 2, 2, 2, 'h200));
    push_ok("push_edge", mk(96, 96, 4, 4, 2, 2, 'h300));
    wait_idle("drain_illegal", 600);
    check("illegal_err_count", n_err - r0, 2);
    check("illegal_done_count", n_done - d0, 2);
    check("illegal_enable_count", n_enable - e0, 2);

    // DONE held high for 3 cycles
    done_hold = 3; d0 = n_done;
    push_ok("push_hold", mk(5, 5, 3, 3, 3, 3, 'h400));
    wait_idle("drain_hold", 300);
    repeat (4) @(negedge clk);
    check("hold_single_done", n_done - d0, 1);
    done_hold = 1;

    // Full FIFO, rejected push, push+pop at full
    never_done = 1'b1; d0 = n_done;
    push_ok("fill_1", mk(1, 1, 4, 4, 4, 4, 'h000));
    push_ok("fill_2", mk(2, 2, 3, 3, 2, 3, 'h040));
    push_ok("fill_3", mk(3, 3, 5, 5, 3, 2, 'h080));
    push_ok("fill_4", mk(4, 4, 2, 2, 2, 2, 'h0C0));
    @(negedge clk);
    check("ready_low_full", job_ready, 0);
    push(mk(9, 9, 2, 2, 2, 2, 'h500), 5, acc, ir);
    check("push_full_ignored", acc, 0);
    never_done = 1'b0;
    push(mk(6, 6, 2, 2, 2, 2, 'h100), 300, acc, ir);
    check("push_at_full_accepted", acc, 1);
    check("push_pop_same_cycle", ir, 1);
    @(negedge clk);
    check("count_held_at_depth", job_ready, 0);
    wait_idle("drain_full", 2000);
    check("full_done_count", n_done - d0, 5);

    // Reset mid-RUN; the job must not replay
    push_ok("push_reset_job", mk(0, 0, 8, 8, 8, 8, 'h000));
    wait_enable("reset_job_started", 100);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_eng_rst", eng_rst, 1);
    check("midrst_eng_enable", eng_enable, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", job_ready, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    e0 = n_enable;
    repeat (30) @(negedge clk);
    check("no_replay_enable", n_enable - e0, 0);
    check("no_replay_busy", busy, 0);
    check("ready_after_midrst", job_ready, 1);

`ifdef BICUBIC_SCHED_TIMEOUT_EN
    // Watchdog abort; the next queued job still starts
    never_done = 1'b1; r0 = n_err;
    j = mk(1, 1, 2, 2, 2, 2, 'h000); j.tmo = 1'b1;
    push_ok("push_tmo_a", j);
    j = mk(2, 2, 2, 2, 2, 2, 'h010); j.tmo = 1'b1;
    push_ok("push_tmo_b", j);
    wait_idle("drain_tmo", 500);
    check("tmo_err_count", n_err - r0, 2);
    never_done = 1'b0;
`endif

    // Randomized jobs
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        j = mk($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 31),
               $urandom_range(0, 31), $urandom_range(0, 8), $urandom_range(0, 8),
               $urandom_range(0, 16383));
      end else begin
        j = mk(0, 0, $urandom_range(2, 16), $urandom_range(2, 16), $urandom_range(1, 8),
               $urandom_range(2, 8), $urandom_range(0, 16383));
        j.v0 = $urandom_range(0, IMG_DIM - j.sh);
        j.h0 = $urandom_range(0, IMG_DIM - j.sw);
      end
      done_hold = $urandom_range(1, 3);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      push_ok("push_rand", j);
    end
    wait_idle("drain_rand", 4000);
    check("queue_empty_at_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
